// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: buffers instructions from the source, tags each with a
// sequential PC and presents the head entry to decode.
module instr_fetch_queue #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     stalled,
  input  logic                     flush,
  input  logic [PC_W-1:0]          flush_pc,
  output logic                     out_valid,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [PC_W-1:0] pc_next;
  logic            enq;
  logic            deq;

  // Ready depends only on flush and registered occupancy; a full queue never bypasses.
  assign in_ready  = reset && (count != CW'(DEPTH)) && !flush;
  assign enq       = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign deq       = out_valid && !stalled;

  // Head is forced to zero when empty so stale storage is never exposed.
  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;

  // Pointers, occupancy and PC counter; flush overrides everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc_next <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc_next <= flush_pc;
    end else begin
      if (enq) begin
        wr_ptr  <= wr_ptr + AW'(1);
        pc_next <= pc_next + PC_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only visible through the gated head.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[wr_ptr] <= '{instr: in_instr, pc: pc_next};
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Front-end stage of the pipelined microcontroller, directly upstream of the decode stage. It accepts instructions from the instruction source over a valid/ready handshake and buffers them in a small FIFO. It tags each instruction with a sequential program counter and presents the head entry to decode. The head is held while the pipeline reports `stalled`, and a synchronous `flush` redirects the stream to a new PC.

## Interface

Parameters:
- `INSTR_W`, 16: instruction width in bits.
- `PC_W`, 8: program-counter width in bits.
- `DEPTH`, 4: number of FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clock`  in  1  Single clock; all state changes on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `in_valid`  in  1  Source offers `in_instr`.
- `in_ready`  out  1  Queue can accept an instruction this cycle.
- `in_instr`  in  INSTR_W  Instruction from the source.
- `stalled`  in  1  Decode/pipeline stall; the head must not advance.
- `flush`  in  1  Discard all buffered entries and redirect the PC.
- `flush_pc`  in  PC_W  PC assigned to the first instruction accepted after a flush.
- `out_valid`  out  1  Head entry is valid for decode.
- `out_instr`  out  INSTR_W  Head instruction.
- `out_pc`  out  PC_W  PC tag of the head instruction.
- `count`  out  $clog2(DEPTH)+1  Number of occupied entries.

## Operation

- Storage is a circular buffer of DEPTH entries, each holding {instr, pc}, with read and write pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - `count` tracks occupancy in the range 0..DEPTH.
- Enqueue happens when `in_valid && in_ready`.
  - The entry is written as {`in_instr`, `pc_next`}.
  - `pc_next` then increments, wrapping modulo 2^PC_W (0xFF+1 → 0x00).
- `in_ready` = `reset` high && `count` != DEPTH && !`flush`. It is combinational from `flush` and registered state only, never from `stalled`.
- Dequeue happens when `out_valid && !stalled`. The read pointer advances.
- `out_valid` = (`count` != 0).
- `out_instr` and `out_pc` are driven from the head entry.
  - They are held stable while `stalled` is high.
  - When `count` == 0 they are 0.
- Simultaneous enqueue and dequeue leaves `count` unchanged and both pointers advance.
- Flush is synchronous and has priority over enqueue and dequeue in the same cycle.
  - Read and write pointers are set to 0 and `count` is set to 0.
  - `pc_next` is loaded with `flush_pc`.
  - `in_ready` is 0 during the flush cycle, so no enqueue occurs.
  - Flush while `stalled` is high still empties the queue.
- Full: `in_ready` = 0. A dequeue in the same cycle does not open a slot until the next cycle (no bypass).
- Empty: `out_valid` = 0, and `stalled` has no effect.

## Timing

- Reset (asynchronous assert, `reset` = 0) forces:
  - `count` = 0, pointers = 0, `pc_next` = 0.
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0.
  - `in_ready` = 0 while reset is asserted.
  - Storage contents are don't-care but are never exposed.
- Reset deassertion is synchronised by the system. `in_ready` = 1 in the first cycle after release.
- Latency: an instruction accepted at edge N is visible with `out_valid` = 1 immediately after edge N (one-cycle fill latency). There is no combinational in→out path.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- A head entry is consumed at the first rising edge where `stalled` = 0. The next entry is visible right after that edge.
- Reset asserted mid-operation discards all entries immediately. Outputs go to reset values without waiting for a clock.

## Test plan

- **Reset and fill to full:** release reset, drive `in_valid` = 1 with 0x1001, 0x1002, 0x1003, 0x1004, 0x1005 and `stalled` = 1.
  - The first four are accepted with PCs 0..3.
  - After the 4th edge, `count` = 4 and `in_ready` = 0.
  - 0x1005 is held by the source.
  - `out_instr` = 0x1001 and `out_pc` = 0 stay stable throughout.
- **Drain under stall toggling:** from full, `stalled` pattern 0,1,0,0.
  - Dequeues 0x1001, 0x1002 and 0x1003 on the stall-low edges.
  - Head is held on the stall-high edge.
  - 0x1005 enters once `in_ready` returns, tagged PC 4.
- **Streaming:** continuous `in_valid` with `stalled` = 0 for 10 cycles.
  - `count` stays 1 after the first edge.
  - `out_pc` increments 0,1,2,… each cycle, one instruction per cycle.
- **PC wrap:** `flush_pc` = 0xFE via flush, then enqueue 3 instructions.
  - Tags are 0xFE, 0xFF, 0x00.
- **Flush priority:** with `count` = 3, `stalled` = 0 and `in_valid` = 1, assert `flush` with `flush_pc` = 0x40.
  - Next cycle: `count` = 0 and `out_valid` = 0.
  - The offered instruction is not accepted (`in_ready` = 0 during flush).
  - Its re-offer is accepted and tagged 0x40.
- **Async reset mid-stream:** with `count` = 2, pulse `reset` low between clock edges.
  - `out_valid`, `out_instr`, `out_pc` and `count` go to 0 immediately.
  - After release, the first accepted instruction is tagged PC 0.
